pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Owns the program counter and drives instruction-memory fetches. Hands fetched instructions to decode through a valid/ready slot.
- Consumes the PC+4 value produced by the external PC adder (PCAddResult) and feeds the current PC back to it (PCResult).
- Applies branch, jump and jump-register redirects from later stages, and squashes wrong-path fetches.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- PCAddResult  in  32  PC+4 from the external adder; next sequential PC.
- PCResult  out  32  current PC register; drives the adder input.
- Branch_Taken  in  1  one-cycle pulse: redirect to Branch_Target.
- Branch_Target  in  32  branch target address.
- Jump  in  1  one-cycle pulse: redirect to Jump_Target.
- Jump_Target  in  32  jump target address.
- JR  in  1  one-cycle pulse: redirect to JR_Target.
- JR_Target  in  32  jump-register target address.
- IMem_Req  out  1  fetch request.
- IMem_Addr  out  32  fetch address; equals PCResult while IMem_Req=1.
- IMem_Ack  in  1  fetch complete; IMem_Data is valid in this cycle.
- IMem_Data  in  32  fetched instruction word.
- Instr_Valid  out  1  output slot holds an instruction.
- Instr  out  32  instruction in the output slot.
- Instr_PC  out  32  address of Instr.
- Instr_Ready  in  1  decode accepts the slot this cycle.

Behaviour:
- Reset (Reset=0 at an edge):
  - state=IDLE; PCResult=RESET_PC.
  - Instr_Valid=0, Instr=0, Instr_PC=0; skid register and RedirPC cleared; IMem_Req=0.
  - Any outstanding memory transaction is abandoned.
- Redirect:
  - Redirect = JR|Jump|Branch_Taken. Priority JR > Jump > Branch.
  - The selected target has bits[1:0] forced to 00.
- Slot handoff: occurs when Instr_Valid=1 and Instr_Ready=1; the slot empties that cycle unless it is reloaded.
- States: IDLE, FETCH, SQUASH, STALLED. IMem_Req=1 only in FETCH and SQUASH.
- IMem_Addr must stay stable from request until IMem_Ack.
- IDLE:
  - Next state FETCH.
  - A redirect here loads PCResult with the target.
- FETCH:
  - Redirect with IMem_Ack: discard IMem_Data; PCResult<=target; Instr_Valid<=0; stay in FETCH.
  - Redirect without IMem_Ack: RedirPC<=target; Instr_Valid<=0; go to SQUASH. PCResult is unchanged, so the address stays stable.
  - IMem_Ack, no redirect, and the slot is empty or handing off: Instr<=IMem_Data, Instr_PC<=PCResult, Instr_Valid<=1, PCResult<=PCAddResult; stay in FETCH. Throughput is 1 instruction/cycle with a single-cycle Ack.
  - IMem_Ack, no redirect, slot full and Instr_Ready=0: skid<=IMem_Data, skid_pc<=PCResult, PCResult<=PCAddResult; go to STALLED.
  - No IMem_Ack: hold; a slot handoff still clears Instr_Valid.
- SQUASH:
  - A new redirect overwrites RedirPC (same priority rules).
  - On IMem_Ack: discard data; PCResult<=RedirPC (or the new target if a redirect is present the same cycle); go to FETCH.
  - Instr_Valid stays 0.
- STALLED:
  - IMem_Req=0.
  - On Instr_Ready: Instr<=skid, Instr_PC<=skid_pc, Instr_Valid stays 1; go to FETCH.
  - On redirect (highest priority): clear slot and skid; PCResult<=target; go to FETCH.
- A redirect and a slot handoff in the same cycle: the handoff completes (decode consumed it), then the slot is cleared.
- Arithmetic: 32-bit, no internal adder. PC wraps only as supplied by PCAddResult (32'hFFFFFFFC+4 → 0).

Test Plan:
- Reset, RESET_PC=0, Ack tied high, Ready=1 → fetch addresses 0,4,8,C on consecutive cycles; Instr_PC follows one cycle later; Instr_Valid=1 from cycle 2.
- Ack arrives 3 cycles after Req at PC=0x10 → IMem_Addr holds 0x10 for 3 cycles; slot gets Instr_PC=0x10; next address is 0x14.
- Redirect Jump=1, Jump_Target=0x203 while a fetch of 0x20 is pending, Ack two cycles later → state SQUASH; 0x20 data discarded, never Instr_Valid; next IMem_Addr=0x200.
- JR, Jump and Branch asserted together with targets 0x100/0x200/0x300 → next IMem_Addr=0x100.
- Ready=0 for 4 cycles with the slot full, then an Ack at 0x40 → STALLED with Req=0; after Ready=1, Instr_PC=0x40 is presented next, then fetch resumes at 0x44.
- Reset=0 asserted mid-SQUASH → next cycle PCResult=RESET_PC, Instr_Valid=0, IMem_Req=0, state IDLE.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// PC owner and instruction-fetch sequencer. It issues IMem requests, hands fetched words to decode
// through a valid/ready slot with a one-entry skid, and applies JR/Jump/Branch redirects.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    output logic [31:0] PCResult,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump,
    input  logic [31:0] Jump_Target,
    input  logic        JR,
    input  logic [31:0] JR_Target,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic        Instr_Valid,
    output logic [31:0] Instr,
    output logic [31:0] Instr_PC,
    input  logic        Instr_Ready
);

    typedef enum logic [1:0] {StIdle, StFetch, StSquash, StStalled} state_e;

    state_e      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_redir_pc, w_redir_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_instr_pc, w_instr_pc_nxt;
    logic        r_instr_valid, w_instr_valid_nxt;
    logic [31:0] r_skid, w_skid_nxt;
    logic [31:0] r_skid_pc, w_skid_pc_nxt;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_handoff;
    logic        w_imem_req;

    assign w_redirect = JR | Jump | Branch_Taken;
    assign w_handoff  = r_instr_valid & Instr_Ready;

    // JR wins over Jump, Jump over Branch; targets are always word-aligned.
    always_comb begin
        w_target = Branch_Target;
        if (JR) begin
            w_target = JR_Target;
        end else if (Jump) begin
            w_target = Jump_Target;
        end
        w_target[1:0] = 2'b00;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state       <= StIdle;
            r_pc          <= RESET_PC;
            r_redir_pc    <= 32'h0;
            r_instr       <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_instr_valid <= 1'b0;
            r_skid        <= 32'h0;
            r_skid_pc     <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_redir_pc    <= w_redir_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_skid        <= w_skid_nxt;
            r_skid_pc     <= w_skid_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_redir_pc_nxt    = r_redir_pc;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;
        w_skid_nxt        = r_skid;
        w_skid_pc_nxt     = r_skid_pc;

        unique case (r_state)
            StIdle: begin
                w_state_nxt = StFetch;
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                end
                if (w_handoff) begin
                    w_instr_valid_nxt = 1'b0;
                end
            end
            StFetch: begin
                if (w_redirect) begin
                    w_instr_valid_nxt = 1'b0;
                    if (IMem_Ack) begin
                        w_pc_nxt = w_target;
                    end else begin
                        // Keep r_pc so the pending request address stays stable until its Ack.
                        w_redir_pc_nxt = w_target;
                        w_state_nxt    = StSquash;
                    end
                end else if (IMem_Ack) begin
                    w_pc_nxt = PCAddResult;
                    if (!r_instr_valid || Instr_Ready) begin
                        w_instr_nxt       = IMem_Data;
                        w_instr_pc_nxt    = r_pc;
                        w_instr_valid_nxt = 1'b1;
                    end else begin
                        w_skid_nxt    = IMem_Data;
                        w_skid_pc_nxt = r_pc;
                        w_state_nxt   = StStalled;
                    end
                end else if (w_handoff) begin
                    w_instr_valid_nxt = 1'b0;
                end
            end
            StSquash: begin
                w_instr_valid_nxt = 1'b0;
                if (w_redirect) begin
                    w_redir_pc_nxt = w_target;
                end
                if (IMem_Ack) begin
                    w_pc_nxt    = w_redirect ? w_target : r_redir_pc;
                    w_state_nxt = StFetch;
                end
            end
            StStalled: begin
                if (w_redirect) begin
                    w_instr_valid_nxt = 1'b0;
                    w_skid_nxt        = 32'h0;
                    w_skid_pc_nxt     = 32'h0;
                    w_pc_nxt          = w_target;
                    w_state_nxt       = StFetch;
                end else if (Instr_Ready) begin
                    w_instr_nxt    = r_skid;
                    w_instr_pc_nxt = r_skid_pc;
                    w_state_nxt    = StFetch;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_comb begin
        w_imem_req = 1'b0;
        unique case (r_state)
            StFetch, StSquash: w_imem_req = 1'b1;
            default:           w_imem_req = 1'b0;
        endcase
    end

    assign PCResult    = r_pc;
    assign IMem_Req    = w_imem_req;
    assign IMem_Addr   = r_pc;
    assign Instr_Valid = r_instr_valid;
    assign Instr       = r_instr;
    assign Instr_PC    = r_instr_pc;

endmodule
